prng_range: RTL and testbench
=============================

Name: prng_range

Overview:
- Parametrised successor to the team's 8-bit XNOR LFSR. Generic-width Fibonacci XNOR LFSR with seed load, plus a req/valid draw engine that returns an unbiased value in [0, RANGE-1] by bounded rejection sampling.
- Serves game logic such as ghost direction choice, scatter timers and fruit placement. Multiple instances may run from different seeds.

Parameters:
- WIDTH, 8: LFSR state width, 4..32.
- TAP_MASK, 8'hB8: feedback tap bitmask, WIDTH bits; bit i set means state[i] is tapped.
- OUT_W, 2: width of the drawn value; OUT_W <= WIDTH.
- RANGE, 4: number of legal outcomes; 1 <= RANGE <= 2**OUT_W.
- MAX_TRIES, 4: draw attempts before the modulo fallback; >= 1.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  free-run step of the LFSR while the FSM is idle.
- seed_load  in  1  load `seed` into the state this cycle.
- seed  in  WIDTH  seed value.
- req  in  1  draw request.
- ready  out  1  FSM idle; a `req` is accepted when `req` and `ready` are both high.
- valid  out  1  one-cycle pulse; `value` is valid.
- value  out  OUT_W  drawn result; holds until the next `valid`.
- state  out  WIDTH  current LFSR state.
- fallback  out  1  sticky per draw: the last result came from the modulo fallback.

Behaviour:
- Step rule: fb = ~^(state & TAP_MASK); next = {state[WIDTH-2:0], fb}.
  - All-zeros is legal. All-ones is the XNOR lockup state.
- Reset values: state=0, FSM=IDLE, ready=1, valid=0, value=0, fallback=0, tries=0.
- State update priority: reset > seed_load > FSM step > enable step.
  - At most one step per cycle.
- FSM states:
  - IDLE:
    - ready=1.
    - If req: step the LFSR, set tries=0, go to DRAW.
    - Else if enable: step the LFSR.
  - DRAW:
    - ready=0. Sample s = state[OUT_W-1:0].
    - If s < RANGE: value<=s, fallback<=0, valid<=1, go to IDLE. No step.
    - Else if tries == MAX_TRIES-1: value<=s % RANGE, fallback<=1, valid<=1, go to IDLE. No step.
    - Else: step, tries<=tries+1. `enable` is ignored in DRAW.
- Latency: req accepted in cycle N; valid high in cycle N+2+k, where k is the number of rejections (k <= MAX_TRIES-1).
- valid is high in IDLE, so ready is also high that cycle. A new req may be accepted in the same cycle as valid (back-to-back draws).
- seed_load during DRAW replaces the state. The draw continues, sampling the new state next cycle; tries is unchanged.
- A req that arrives while ready=0 is ignored; the requester must hold req.
- Reset mid-draw aborts with no valid pulse.
- RANGE == 2**OUT_W: every sample is accepted, so latency is always 2.

Optional Feature:
- Macro PRNG_LOCKUP_RECOVER_EN.
- Defined: whenever the state is all-ones (reached by seed_load or by stepping), the next update that would step forces the state to 0 instead.
- Not defined: all-ones persists, the stream is constant, and draws repeat the same value.

Decomposition:
- Package prng_pkg holds:
  - the FSM state enum (IDLE, DRAW);
  - a function lfsr_next(state, mask);
  - localparams of maximal-length tap masks for widths 8 (8'hB8), 16 (16'hB400) and 32 (32'h80200003).
- Sub-module lfsr_core (clk, reset, load, seed, step, state) holds the state register and step rule, including the lockup macro. prng_range instantiates it and owns the FSM.

Test Plan:
1. Reset, enable=1, no req -> state sequence 00,01,03,07,0F,1E,3D on successive cycles.
2. RANGE=3, OUT_W=2, reset, enable=0; req for one cycle -> step to 01; valid in cycle N+2 with value=1, fallback=0.
3. Same config, second req from state 01 -> rejects on 03, 07, 0F, accepts on 1E; valid at N+5 with value=2.
4. MAX_TRIES=2, state 01, req -> reject 03, fallback at 07; valid at N+3 with value=0 (3%3), fallback=1.
5. seed_load=1 with seed=0x55 during DRAW -> next sample uses 0x55 (low bits 1, <3); value=1 the following cycle.
6. Seed 0xFF, enable=1 -> with PRNG_LOCKUP_RECOVER_EN the next state is 0x00 then 0x01; without it the state stays 0xFF.

Source files
------------

// File: rtl/prng_pkg.sv
// Shared types and helpers for the range-limited PRNG: draw FSM encoding,
// the XNOR Fibonacci step function and known maximal-length tap masks.
package prng_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        DRAW = 1'b1
    } fsm_e;

    localparam logic [7:0]  TAP_MASK_8  = 8'hB8;
    localparam logic [15:0] TAP_MASK_16 = 16'hB400;
    localparam logic [31:0] TAP_MASK_32 = 32'h80200003;

    // Operates on a 32-bit container; callers zero-extend and truncate to their width.
    function automatic logic [31:0] lfsr_next(input logic [31:0] state, input logic [31:0] mask);
        return {state[30:0], ~^(state & mask)};
    endfunction

endpackage

// File: rtl/lfsr_core.sv
// XNOR Fibonacci LFSR state register with seed load and single-step control.
// PRNG_LOCKUP_RECOVER_EN: when defined, a step from all-ones forces the state to zero.
module lfsr_core
    import prng_pkg::*;
#(
    parameter int unsigned      WIDTH    = 8,
    parameter logic [WIDTH-1:0] TAP_MASK = WIDTH'(TAP_MASK_8)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] seed,
    input  logic             step,
    output logic [WIDTH-1:0] state
);

    logic [WIDTH-1:0] state_q;
    logic [WIDTH-1:0] state_d;

    always_comb begin
        state_d = state_q;
        if (load) begin
            state_d = seed;
        end else if (step) begin
`ifdef PRNG_LOCKUP_RECOVER_EN
            if (&state_q) begin
                state_d = '0;
            end else begin
                state_d = WIDTH'(lfsr_next(32'(state_q), 32'(TAP_MASK)));
            end
`else
            state_d = WIDTH'(lfsr_next(32'(state_q), 32'(TAP_MASK)));
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= '0;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

endmodule

// File: rtl/prng_range.sv
// Free-running LFSR plus a req/valid engine returning unbiased values in [0, RANGE-1]
// by bounded rejection sampling with a modulo fallback. Lockup handling: PRNG_LOCKUP_RECOVER_EN.
//   state | meaning
//   IDLE  | ready for req; LFSR free-runs on enable
//   DRAW  | sampling low OUT_W bits, stepping on each rejection
module prng_range
    import prng_pkg::*;
#(
    parameter int unsigned      WIDTH     = 8,
    parameter logic [WIDTH-1:0] TAP_MASK  = WIDTH'(TAP_MASK_8),
    parameter int unsigned      OUT_W     = 2,
    parameter int unsigned      RANGE     = 4,
    parameter int unsigned      MAX_TRIES = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             seed_load,
    input  logic [WIDTH-1:0] seed,
    input  logic             req,
    output logic             ready,
    output logic             valid,
    output logic [OUT_W-1:0] value,
    output logic [WIDTH-1:0] state,
    output logic             fallback
);

    localparam int unsigned      TRY_W    = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
    localparam logic [TRY_W-1:0] LAST_TRY = TRY_W'(MAX_TRIES - 1);

    fsm_e             fsm_q, fsm_d;
    logic [TRY_W-1:0] tries_q, tries_d;
    logic             valid_q, valid_d;
    logic [OUT_W-1:0] value_q, value_d;
    logic             fallback_q, fallback_d;

    logic             step;
    logic [WIDTH-1:0] lfsr_state;
    logic [OUT_W-1:0] sample;
    logic             accept;

    lfsr_core #(
        .WIDTH    (WIDTH),
        .TAP_MASK (TAP_MASK)
    ) u_lfsr (
        .clk   (clk),
        .reset (reset),
        .load  (seed_load),
        .seed  (seed),
        .step  (step),
        .state (lfsr_state)
    );

    assign sample = lfsr_state[OUT_W-1:0];
    assign accept = (32'(sample) < RANGE);

    always_comb begin
        fsm_d      = fsm_q;
        tries_d    = tries_q;
        valid_d    = 1'b0;
        value_d    = value_q;
        fallback_d = fallback_q;
        step       = 1'b0;
        case (fsm_q)
            IDLE: begin
                if (req) begin
                    step    = 1'b1;
                    tries_d = '0;
                    fsm_d   = DRAW;
                end else if (enable) begin
                    step = 1'b1;
                end
            end
            DRAW: begin
                if (accept) begin
                    value_d    = sample;
                    fallback_d = 1'b0;
                    valid_d    = 1'b1;
                    fsm_d      = IDLE;
                end else if (tries_q == LAST_TRY) begin
                    value_d    = OUT_W'(32'(sample) % RANGE);
                    fallback_d = 1'b1;
                    valid_d    = 1'b1;
                    fsm_d      = IDLE;
                end else if (!seed_load) begin
                    // A concurrent seed load replaces this attempt without consuming a try.
                    step    = 1'b1;
                    tries_d = tries_q + 1'b1;
                end
            end
            default: fsm_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fsm_q      <= IDLE;
            tries_q    <= '0;
            valid_q    <= 1'b0;
            value_q    <= '0;
            fallback_q <= 1'b0;
        end else begin
            fsm_q      <= fsm_d;
            tries_q    <= tries_d;
            valid_q    <= valid_d;
            value_q    <= value_d;
            fallback_q <= fallback_d;
        end
    end

    assign ready    = (fsm_q == IDLE);
    assign valid    = valid_q;
    assign value    = value_q;
    assign fallback = fallback_q;
    assign state    = lfsr_state;

endmodule

// File: tb/tb_prng_range.sv
// Directed bench for prng_range: three instances share stimulus (RANGE=3/MAX_TRIES=4,
// RANGE=3/MAX_TRIES=2, RANGE=4/MAX_TRIES=4) so one draw exercises several configurations.
module tb_prng_range;

    logic       clk;
    logic       reset;
    logic       enable;
    logic       seed_load;
    logic [7:0] seed;
    logic       req;

    logic       a_ready, a_valid, a_fallback;
    logic [1:0] a_value;
    logic [7:0] a_state;
    logic       b_ready, b_valid, b_fallback;
    logic [1:0] b_value;
    logic [7:0] b_state;
    logic       c_ready, c_valid, c_fallback;
    logic [1:0] c_value;
    logic [7:0] c_state;

    int checks = 0;
    int errors = 0;

    prng_range #(.WIDTH(8), .TAP_MASK(8'hB8), .OUT_W(2), .RANGE(3), .MAX_TRIES(4)) dut_a (
        .clk(clk), .reset(reset), .enable(enable), .seed_load(seed_load), .seed(seed),
        .req(req), .ready(a_ready), .valid(a_valid), .value(a_value), .state(a_state),
        .fallback(a_fallback)
    );

    prng_range #(.WIDTH(8), .TAP_MASK(8'hB8), .OUT_W(2), .RANGE(3), .MAX_TRIES(2)) dut_b (
        .clk(clk), .reset(reset), .enable(enable), .seed_load(seed_load), .seed(seed),
        .req(req), .ready(b_ready), .valid(b_valid), .value(b_value), .state(b_state),
        .fallback(b_fallback)
    );

    prng_range #(.WIDTH(8), .TAP_MASK(8'hB8), .OUT_W(2), .RANGE(4), .MAX_TRIES(4)) dut_c (
        .clk(clk), .reset(reset), .enable(enable), .seed_load(seed_load), .seed(seed),
        .req(req), .ready(c_ready), .valid(c_valid), .value(c_value), .state(c_state),
        .fallback(c_fallback)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_reset();
        reset     = 1'b1;
        enable    = 1'b0;
        seed_load = 1'b0;
        seed      = 8'h00;
        req       = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic load_seed(input logic [7:0] s);
        seed_load = 1'b1;
        seed      = s;
        @(negedge clk);
        seed_load = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (a_state !== 8'h00) begin errors++; $display("FAIL reset_state got %h exp 00", a_state); end
        checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", a_ready); end
        checks++; if (a_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", a_valid); end
        checks++; if (a_value !== 2'd0) begin errors++; $display("FAIL reset_value got %0d exp 0", a_value); end
        checks++; if (a_fallback !== 1'b0) begin errors++; $display("FAIL reset_fallback got %b exp 0", a_fallback); end
    endtask

    task automatic test_free_run();
        logic [7:0] exp_seq [6];
        exp_seq = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1E, 8'h3D};
        do_reset();
        enable = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checks++;
            if (a_state !== exp_seq[i]) begin
                errors++;
                $display("FAIL free_run[%0d] got %h exp %h", i, a_state, exp_seq[i]);
            end
        end
        enable = 1'b0;
    endtask

    task automatic test_single_draw();
        do_reset();
        req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        checks++; if (a_state !== 8'h01) begin errors++; $display("FAIL single_step got %h exp 01", a_state); end
        checks++; if (a_ready !== 1'b0 || a_valid !== 1'b0) begin errors++; $display("FAIL single_busy ready=%b valid=%b exp 0/0", a_ready, a_valid); end
        @(negedge clk);
        checks++; if (a_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %b exp 1", a_valid); end
        checks++; if (a_value !== 2'd1) begin errors++; $display("FAIL single_value got %0d exp 1", a_value); end
        checks++; if (a_fallback !== 1'b0) begin errors++; $display("FAIL single_fallback got %b exp 0", a_fallback); end
        checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL single_ready got %b exp 1", a_ready); end
        checks++; if (c_valid !== 1'b1 || c_value !== 2'd1) begin errors++; $display("FAIL single_full_range valid=%b value=%0d exp 1/1", c_valid, c_value); end
        @(negedge clk);
        checks++; if (a_valid !== 1'b0) begin errors++; $display("FAIL single_pulse got %b exp 0", a_valid); end
        checks++; if (a_value !== 2'd1) begin errors++; $display("FAIL single_hold got %0d exp 1", a_value); end
    endtask

    // Continues from state 01 left by test_single_draw.
    task automatic test_rejection();
        int lat_a = -1, lat_b = -1, lat_c = -1;
        int cnt_a = 0;
        logic [1:0] val_a = 2'd0, val_b = 2'd0, val_c = 2'd0;
        logic fb_a = 1'b0, fb_b = 1'b0;
        req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (a_valid === 1'b1) begin
                cnt_a++;
                if (lat_a < 0) begin lat_a = i; val_a = a_value; fb_a = a_fallback; end
            end
            if (b_valid === 1'b1 && lat_b < 0) begin lat_b = i; val_b = b_value; fb_b = b_fallback; end
            if (c_valid === 1'b1 && lat_c < 0) begin lat_c = i; val_c = c_value; end
        end
        checks++; if (lat_a !== 4) begin errors++; $display("FAIL reject_latency got %0d exp 4", lat_a); end
        checks++; if (val_a !== 2'd2) begin errors++; $display("FAIL reject_value got %0d exp 2", val_a); end
        checks++; if (fb_a !== 1'b0) begin errors++; $display("FAIL reject_fallback got %b exp 0", fb_a); end
        checks++; if (cnt_a !== 1) begin errors++; $display("FAIL reject_pulse_count got %0d exp 1", cnt_a); end
        checks++; if (a_state !== 8'h1E) begin errors++; $display("FAIL reject_state got %h exp 1E", a_state); end
        checks++; if (lat_b !== 2) begin errors++; $display("FAIL fallback_latency got %0d exp 2", lat_b); end
        checks++; if (val_b !== 2'd0) begin errors++; $display("FAIL fallback_value got %0d exp 0", val_b); end
        checks++; if (fb_b !== 1'b1) begin errors++; $display("FAIL fallback_flag got %b exp 1", fb_b); end
        checks++; if (lat_c !== 1) begin errors++; $display("FAIL full_range_latency got %0d exp 1", lat_c); end
        checks++; if (val_c !== 2'd3) begin errors++; $display("FAIL full_range_value got %0d exp 3", val_c); end
    endtask

    task automatic test_seed_during_draw();
        do_reset();
        load_seed(8'h01);
        checks++; if (a_state !== 8'h01) begin errors++; $display("FAIL seed_idle got %h exp 01", a_state); end
        req = 1'b1;
        @(negedge clk);
        req       = 1'b0;
        seed_load = 1'b1;
        seed      = 8'h55;
        checks++; if (a_state !== 8'h03 || a_ready !== 1'b0) begin errors++; $display("FAIL seed_draw_start state=%h ready=%b exp 03/0", a_state, a_ready); end
        @(negedge clk);
        seed_load = 1'b0;
        checks++; if (a_state !== 8'h55) begin errors++; $display("FAIL seed_draw_load got %h exp 55", a_state); end
        checks++; if (a_valid !== 1'b0 || a_ready !== 1'b0) begin errors++; $display("FAIL seed_draw_busy valid=%b ready=%b exp 0/0", a_valid, a_ready); end
        checks++; if (c_valid !== 1'b1 || c_value !== 2'd3) begin errors++; $display("FAIL seed_full_range valid=%b value=%0d exp 1/3", c_valid, c_value); end
        @(negedge clk);
        checks++; if (a_valid !== 1'b1 || a_value !== 2'd1) begin errors++; $display("FAIL seed_draw_result valid=%b value=%0d exp 1/1", a_valid, a_value); end
        checks++; if (a_fallback !== 1'b0 || a_state !== 8'h55) begin errors++; $display("FAIL seed_draw_post fallback=%b state=%h exp 0/55", a_fallback, a_state); end
        checks++; if (b_valid !== 1'b1 || b_value !== 2'd1) begin errors++; $display("FAIL seed_draw_tries valid=%b value=%0d exp 1/1", b_valid, b_value); end
    endtask

    task automatic test_back_to_back();
        int lat = -1;
        logic [1:0] val = 2'd0;
        do_reset();
        req = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++; if (a_valid !== 1'b1 || a_ready !== 1'b1 || a_value !== 2'd1) begin errors++; $display("FAIL b2b_first valid=%b ready=%b value=%0d exp 1/1/1", a_valid, a_ready, a_value); end
        @(negedge clk);
        req = 1'b0;
        checks++; if (a_valid !== 1'b0 || a_ready !== 1'b0 || a_state !== 8'h03) begin errors++; $display("FAIL b2b_accept valid=%b ready=%b state=%h exp 0/0/03", a_valid, a_ready, a_state); end
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (a_valid === 1'b1 && lat < 0) begin lat = i; val = a_value; end
        end
        checks++; if (lat !== 4 || val !== 2'd2) begin errors++; $display("FAIL b2b_second latency=%0d value=%0d exp 4/2", lat, val); end
    endtask

    task automatic test_reset_mid_draw();
        do_reset();
        load_seed(8'h01);
        req = 1'b1;
        @(negedge clk);
        req   = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++; if (a_valid !== 1'b0 || a_ready !== 1'b1 || a_state !== 8'h00) begin errors++; $display("FAIL abort_state valid=%b ready=%b state=%h exp 0/1/00", a_valid, a_ready, a_state); end
        @(negedge clk);
        checks++; if (a_valid !== 1'b0 || a_state !== 8'h00) begin errors++; $display("FAIL abort_no_pulse valid=%b state=%h exp 0/00", a_valid, a_state); end
    endtask

    task automatic test_lockup();
        do_reset();
        load_seed(8'hFF);
        checks++; if (a_state !== 8'hFF) begin errors++; $display("FAIL lockup_seed got %h exp FF", a_state); end
        enable = 1'b1;
        @(negedge clk);
`ifdef PRNG_LOCKUP_RECOVER_EN
        checks++; if (a_state !== 8'h00) begin errors++; $display("FAIL lockup_recover1 got %h exp 00", a_state); end
        @(negedge clk);
        checks++; if (a_state !== 8'h01) begin errors++; $display("FAIL lockup_recover2 got %h exp 01", a_state); end
        enable = 1'b0;
`else
        checks++; if (a_state !== 8'hFF) begin errors++; $display("FAIL lockup_hold1 got %h exp FF", a_state); end
        @(negedge clk);
        checks++; if (a_state !== 8'hFF) begin errors++; $display("FAIL lockup_hold2 got %h exp FF", a_state); end
        enable = 1'b0;
        begin
            int lat = -1;
            logic [1:0] val = 2'd3;
            logic fb = 1'b0;
            req = 1'b1;
            @(negedge clk);
            req = 1'b0;
            for (int i = 1; i <= 8; i++) begin
                @(negedge clk);
                if (a_valid === 1'b1 && lat < 0) begin lat = i; val = a_value; fb = a_fallback; end
            end
            checks++; if (lat !== 4 || val !== 2'd0 || fb !== 1'b1) begin errors++; $display("FAIL lockup_draw latency=%0d value=%0d fallback=%b exp 4/0/1", lat, val, fb); end
        end
`endif
    endtask

    initial begin
        reset     = 1'b1;
        enable    = 1'b0;
        seed_load = 1'b0;
        seed      = 8'h00;
        req       = 1'b0;
        test_reset();
        test_free_run();
        test_single_draw();
        test_rejection();
        test_seed_during_draw();
        test_back_to_back();
        test_reset_mid_draw();
        test_lockup();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
